// File: rtl/conv_window_addr_gen.sv
// Sliding-window read-address generator: walks KxK taps over every output position and channel pass.
// Optional macro CONV_STALL_EN adds i_out_ready back-pressure; undefined means the generator never stalls.
module conv_window_addr_gen #(
    parameter int unsigned K       = 5,
    parameter int unsigned DIM_W   = 6,
    parameter int unsigned CH_W    = 5,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned WADDR_W = 9,
    parameter int unsigned CLR_DLY = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [DIM_W-1:0]   i_w,
    input  logic [DIM_W-1:0]   i_h,
    input  logic [CH_W-1:0]    i_c,
    input  logic [1:0]         i_stride,
`ifdef CONV_STALL_EN
    input  logic               i_out_ready,
`endif
    output logic               o_rd_en,
    output logic [ADDR_W-1:0]  o_img_addr,
    output logic [WADDR_W-1:0] o_wgt_addr,
    output logic               o_win_first,
    output logic               o_win_last,
    output logic               o_acc_clear,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_cfg_err
);

    localparam int unsigned        KC_W    = (K > 1) ? $clog2(K) : 1;
    localparam logic [KC_W-1:0]    K_MAX   = KC_W'(K - 1);
    localparam logic [CLR_DLY-1:0] CLR_TOP = CLR_DLY'(1) << (CLR_DLY - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} state_t;

    state_t              r_state, w_state_d;
    logic [DIM_W-1:0]    r_w, r_e_max, r_f_max;
    logic [CH_W-1:0]     r_c_max;
    logic                r_s2;
    logic [KC_W-1:0]     r_kw, r_kh, w_kw_d, w_kh_d;
    logic [DIM_W-1:0]    r_e, r_f, w_e_d, w_f_d;
    logic [CH_W-1:0]     r_c, w_c_d;
    logic                r_rd_en, r_win_first, r_win_last, r_busy, r_done, r_cfg_err;
    logic [ADDR_W-1:0]   r_img_addr, w_img_addr, w_row, w_col;
    logic [WADDR_W-1:0]  r_wgt_addr, w_wgt_addr;
    logic [CLR_DLY-1:0]  r_clr_sr, w_clr_d;
    logic                w_xfer, w_fire, w_final_clr, w_cfg_ok, w_last_tap;
    logic                w_accept, w_load, w_stop, w_done_set, w_cfg_err_d;
    logic [DIM_W-1:0]    w_wd, w_hd;

`ifdef CONV_STALL_EN
    assign w_xfer = r_rd_en && i_out_ready;
`else
    assign w_xfer = r_rd_en;
`endif

    assign w_fire      = w_xfer && r_win_last;
    assign w_clr_d     = (r_clr_sr << 1) | CLR_DLY'(w_fire);
    // Only the newest pending clear remains when just the top bit survives the shift.
    assign w_final_clr = (w_clr_d == CLR_TOP);

    assign w_cfg_ok = (i_w >= DIM_W'(K)) && (i_h >= DIM_W'(K)) && (i_c != '0) &&
                      ((i_stride == 2'd1) || (i_stride == 2'd2));
    assign w_wd     = i_w - DIM_W'(K);
    assign w_hd     = i_h - DIM_W'(K);

    assign w_last_tap = (r_kw == K_MAX) && (r_kh == K_MAX) && (r_e == r_e_max) &&
                        (r_f == r_f_max) && (r_c == r_c_max);

    always_comb begin
        w_state_d   = r_state;
        w_kw_d      = r_kw;
        w_kh_d      = r_kh;
        w_e_d       = r_e;
        w_f_d       = r_f;
        w_c_d       = r_c;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_stop      = 1'b0;
        w_done_set  = 1'b0;
        w_cfg_err_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (w_cfg_ok) begin
                        w_accept  = 1'b1;
                        w_state_d = StLoad;
                        w_kw_d    = '0;
                        w_kh_d    = '0;
                        w_e_d     = '0;
                        w_f_d     = '0;
                        w_c_d     = '0;
                    end else begin
                        w_cfg_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                w_load    = 1'b1;
                w_state_d = StRun;
            end
            StRun: begin
                if (w_xfer) begin
                    if (w_last_tap) begin
                        w_stop = 1'b1;
                        if (w_final_clr) begin
                            w_state_d  = StIdle;
                            w_done_set = 1'b1;
                        end else begin
                            w_state_d = StDrain;
                        end
                    end else begin
                        w_load = 1'b1;
                        w_kw_d = (r_kw == K_MAX) ? '0 : r_kw + KC_W'(1);
                        if (r_kw == K_MAX) begin
                            w_kh_d = (r_kh == K_MAX) ? '0 : r_kh + KC_W'(1);
                            if (r_kh == K_MAX) begin
                                w_e_d = (r_e == r_e_max) ? '0 : r_e + DIM_W'(1);
                                if (r_e == r_e_max) begin
                                    w_f_d = (r_f == r_f_max) ? '0 : r_f + DIM_W'(1);
                                    if (r_f == r_f_max) begin
                                        w_c_d = r_c + CH_W'(1);
                                    end
                                end
                            end
                        end
                    end
                end
            end
            StDrain: begin
                if (w_final_clr) begin
                    w_state_d  = StIdle;
                    w_done_set = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Addresses are computed from the next counter values so they can be registered.
    assign w_row      = (ADDR_W'(w_f_d) << r_s2) + ADDR_W'(w_kh_d);
    assign w_col      = (ADDR_W'(w_e_d) << r_s2) + ADDR_W'(w_kw_d);
    assign w_img_addr = ADDR_W'(r_w) * w_row + w_col;
    assign w_wgt_addr = WADDR_W'(w_c_d) * WADDR_W'(K * K) + WADDR_W'(w_kh_d) * WADDR_W'(K) +
                        WADDR_W'(w_kw_d);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_w         <= '0;
            r_e_max     <= '0;
            r_f_max     <= '0;
            r_c_max     <= '0;
            r_s2        <= 1'b0;
            r_kw        <= '0;
            r_kh        <= '0;
            r_e         <= '0;
            r_f         <= '0;
            r_c         <= '0;
            r_rd_en     <= 1'b0;
            r_img_addr  <= '0;
            r_wgt_addr  <= '0;
            r_win_first <= 1'b0;
            r_win_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_clr_sr    <= '0;
        end else begin
            r_state   <= w_state_d;
            r_kw      <= w_kw_d;
            r_kh      <= w_kh_d;
            r_e       <= w_e_d;
            r_f       <= w_f_d;
            r_c       <= w_c_d;
            r_busy    <= (w_state_d == StRun) || (w_state_d == StDrain);
            r_cfg_err <= w_cfg_err_d;
            r_clr_sr  <= w_clr_d;
            if (w_accept) begin
                r_w     <= i_w;
                r_s2    <= (i_stride == 2'd2);
                r_e_max <= (i_stride == 2'd2) ? (w_wd >> 1) : w_wd;
                r_f_max <= (i_stride == 2'd2) ? (w_hd >> 1) : w_hd;
                r_c_max <= i_c - CH_W'(1);
                r_done  <= 1'b0;
            end else if (w_done_set) begin
                r_done <= 1'b1;
            end
            if (w_load) begin
                r_rd_en     <= 1'b1;
                r_img_addr  <= w_img_addr;
                r_wgt_addr  <= w_wgt_addr;
                r_win_first <= (w_kw_d == '0) && (w_kh_d == '0);
                r_win_last  <= (w_kw_d == K_MAX) && (w_kh_d == K_MAX);
            end else if (w_stop) begin
                r_rd_en     <= 1'b0;
                r_win_first <= 1'b0;
                r_win_last  <= 1'b0;
            end
        end
    end

    assign o_rd_en     = r_rd_en;
    assign o_img_addr  = r_img_addr;
    assign o_wgt_addr  = r_wgt_addr;
    assign o_win_first = r_win_first;
    assign o_win_last  = r_win_last;
    assign o_acc_clear = r_clr_sr[CLR_DLY-1];
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Scoreboard bench for conv_window_addr_gen: a K=5 and a K=3 instance driven by directed jobs.
`timescale 1ns/1ps
module tb_conv_window_addr_gen;
    localparam int DIM_W = 6, CH_W = 5, ADDR_W = 10, WADDR_W = 9, CLR_DLY = 4;
    localparam int EW = 2 + WADDR_W + ADDR_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start [2];
    logic [DIM_W-1:0]   w_in, h_in;
    logic [CH_W-1:0]    c_in;
    logic [1:0]         s_in;
    logic               out_ready;
    logic               rd_en [2], win_first [2], win_last [2], acc_clear [2];
    logic               busy [2], done [2], cfg_err [2];
    logic [ADDR_W-1:0]  img [2];
    logic [WADDR_W-1:0] wgt [2];

    int total = 0, bad = 0, cyc = 0;
    bit stall_on = 1'b0;
    logic [EW-1:0]     exp_q [2][$];
    int                clr_q [2][$];
    logic [ADDR_W-1:0] win_start [2][$];
    int                n_xfer [2], n_clr [2];

    conv_window_addr_gen #(.K(5), .DIM_W(DIM_W), .CH_W(CH_W), .ADDR_W(ADDR_W),
                           .WADDR_W(WADDR_W), .CLR_DLY(CLR_DLY)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_w(w_in), .i_h(h_in),
        .i_c(c_in), .i_stride(s_in),
`ifdef CONV_STALL_EN
        .i_out_ready(out_ready),
`endif
        .o_rd_en(rd_en[0]), .o_img_addr(img[0]), .o_wgt_addr(wgt[0]),
        .o_win_first(win_first[0]), .o_win_last(win_last[0]), .o_acc_clear(acc_clear[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_cfg_err(cfg_err[0]));

    conv_window_addr_gen #(.K(3), .DIM_W(DIM_W), .CH_W(CH_W), .ADDR_W(ADDR_W),
                           .WADDR_W(WADDR_W), .CLR_DLY(CLR_DLY)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_w(w_in), .i_h(h_in),
        .i_c(c_in), .i_stride(s_in),
`ifdef CONV_STALL_EN
        .i_out_ready(out_ready),
`endif
        .o_rd_en(rd_en[1]), .o_img_addr(img[1]), .o_wgt_addr(wgt[1]),
        .o_win_first(win_first[1]), .o_win_last(win_last[1]), .o_acc_clear(acc_clear[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_cfg_err(cfg_err[1]));

    always #5 clk = ~clk;

    function automatic int kval(int d);
        return (d == 0) ? 5 : 3;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample just after the edge, then score transfers and acc_clear pulses.
    task automatic tick();
        logic [EW-1:0] obs;
        @(posedge clk);
        #1;
        cyc++;
        out_ready = stall_on ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (acc_clear[d]) begin
                n_clr[d]++;
                chk("clr_pending", 32'(clr_q[d].size() != 0), 1);
                if (clr_q[d].size() != 0) chk("clr_time", 32'(cyc), 32'(clr_q[d].pop_front()));
            end
            if (rd_en[d] && out_ready) begin
                n_xfer[d]++;
                obs = {win_first[d], win_last[d], wgt[d], img[d]};
                if (win_first[d]) win_start[d].push_back(img[d]);
                if (win_last[d]) clr_q[d].push_back(cyc + CLR_DLY);
                chk("sb_nonempty", 32'(exp_q[d].size() != 0), 1);
                if (exp_q[d].size() != 0) chk("xfer", 32'(obs), 32'(exp_q[d].pop_front()));
            end
        end
    endtask

    task automatic push_job(int d, int w, int h, int c, int s);
        int k = kval(d);
        int ne = (w - k) / s + 1;
        int nf = (h - k) / s + 1;
        for (int cc = 0; cc < c; cc++)
            for (int ff = 0; ff < nf; ff++)
                for (int ee = 0; ee < ne; ee++)
                    for (int kh = 0; kh < k; kh++)
                        for (int kw = 0; kw < k; kw++) begin
                            int ia = (w * (ff * s + kh) + ee * s + kw) % (1 << ADDR_W);
                            int wa = (cc * k * k + kh * k + kw) % (1 << WADDR_W);
                            exp_q[d].push_back({(kh == 0 && kw == 0), (kh == k - 1 && kw == k - 1),
                                                WADDR_W'(wa), ADDR_W'(ia)});
                        end
    endtask

    task automatic set_cfg(int w, int h, int c, int s);
        w_in = DIM_W'(w);
        h_in = DIM_W'(h);
        c_in = CH_W'(c);
        s_in = 2'(s);
    endtask

    task automatic run_job(int d, int w, int h, int c, int s, bit mid_start);
        int k = kval(d);
        int windows = c * ((w - k) / s + 1) * ((h - k) / s + 1);
        int n = windows * k * k;
        int c0;
        push_job(d, w, h, c, s);
        n_xfer[d] = 0;
        n_clr[d] = 0;
        win_start[d].delete();
        set_cfg(w, h, c, s);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        c0 = cyc;
        chk("busy_at_accept", 32'(busy[d]), 0);
        chk("rd_en_at_accept", 32'(rd_en[d]), 0);
        tick();
        chk("first_rd_en", 32'(rd_en[d]), 1);
        chk("first_busy", 32'(busy[d]), 1);
        for (int i = 0; i < 4 * n + 200 && !done[d]; i++) begin
            start[d] = (mid_start && i == 20);
            tick();
            if (mid_start && i == 20) chk("busy_start_no_err", 32'(cfg_err[d]), 0);
        end
        start[d] = 1'b0;
        chk("done", 32'(done[d]), 1);
        chk("busy_end", 32'(busy[d]), 0);
        chk("clr_with_done", 32'(acc_clear[d]), 1);
        if (!stall_on) chk("job_len", 32'(cyc - c0), 32'(n + CLR_DLY));
        chk("xfer_count", 32'(n_xfer[d]), 32'(n));
        chk("clr_count", 32'(n_clr[d]), 32'(windows));
        chk("sb_drained", 32'(exp_q[d].size() + clr_q[d].size()), 0);
    endtask

    task automatic bad_cfg(int w, int s, string tag);
        set_cfg(w, 6, 1, s);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk({tag, "_cfg_err"}, 32'(cfg_err[0]), 1);
        chk({tag, "_busy"}, 32'(busy[0]), 0);
        chk({tag, "_done_kept"}, 32'(done[0]), 1);
        tick();
        chk({tag, "_err_pulse"}, 32'(cfg_err[0]), 0);
        chk({tag, "_no_rd"}, 32'(rd_en[0] | busy[0]), 0);
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "_rd_en"}, 32'(rd_en[0]), 0);
        chk({tag, "_img"}, 32'(img[0]), 0);
        chk({tag, "_wgt"}, 32'(wgt[0]), 0);
        chk({tag, "_strobes"}, 32'({win_first[0], win_last[0], acc_clear[0]}), 0);
        chk({tag, "_status"}, 32'({busy[0], done[0], cfg_err[0]}), 0);
    endtask

    task automatic chk_win_a(string tag);
        chk({tag, "_w1"}, 32'(win_start[0][1]), 1);
        chk({tag, "_w2"}, 32'(win_start[0][2]), 6);
        chk({tag, "_w3"}, 32'(win_start[0][3]), 7);
    endtask

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        out_ready = 1'b1;
        set_cfg(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_job(0, 6, 6, 1, 1, 1'b0);
        chk_win_a("jobA");
        run_job(1, 9, 9, 1, 2, 1'b0);
        chk("jobB_e1", 32'(win_start[1][1]), 2);
        chk("jobB_f1", 32'(win_start[1][4]), 18);
        run_job(0, 5, 5, 3, 1, 1'b0);

        bad_cfg(4, 1, "narrow_w");
        bad_cfg(6, 0, "stride0");
        run_job(0, 6, 6, 1, 1, 1'b1);

        // Async reset partway through a window.
        push_job(0, 6, 6, 1, 1);
        set_cfg(6, 6, 1, 1);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (32) tick();
        rst_n = 1'b0;
        #1;
        chk_quiet("mid_reset");
        exp_q[0].delete();
        clr_q[0].delete();
        repeat (CLR_DLY + 2) tick();
        chk_quiet("held_reset");
        rst_n = 1'b1;
        tick();
        run_job(0, 6, 6, 1, 1, 1'b0);
        chk_win_a("after_reset");

`ifdef CONV_STALL_EN
        stall_on = 1'b1;
        run_job(0, 6, 6, 1, 1, 1'b0);
        run_job(1, 9, 9, 1, 2, 1'b0);
        run_job(0, 5, 5, 3, 1, 1'b0);
        stall_on = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
